// File: rtl/seg7_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : seg7_pkg                                                  |
// | Purpose  : Shared constants and helpers for the seven-segment scan   |
// |            driver: blank pattern, hex decode table, slot length and  |
// |            counter width helpers.                                    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package seg7_pkg;

  // Active-low {g,f,e,d,c,b,a}: all segments off.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
  };

  // Clock cycles per digit slot.
  function automatic int tick_cycles(input int clk_hz, input int refresh_hz);
    return clk_hz / refresh_hz;
  endfunction

  // Bits needed to count 0..n-1 (never less than one bit).
  function automatic int width_for(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_scan_driver_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : seg7_scan_driver_if                                       |
// | Purpose  : Display value/control inputs and board pin outputs of     |
// |            the scan driver.                                          |
// | Ports    : en, value[4*DIGITS], dp_in[DIGITS], load, blank_lz  (in)  |
// |            an[DIGITS], seg[7], dp, frame_done                  (out) |
// |            master = core side, slave = driver side                   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface seg7_scan_driver_if #(
  parameter int DIGITS = 4
);
  logic                  en;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp_in;
  logic                  load;
  logic                  blank_lz;
  logic [DIGITS-1:0]     an;
  logic [6:0]            seg;
  logic                  dp;
  logic                  frame_done;

  modport master (
    output en, value, dp_in, load, blank_lz,
    input  an, seg, dp, frame_done
  );

  modport slave (
    input  en, value, dp_in, load, blank_lz,
    output an, seg, dp, frame_done
  );
endinterface : seg7_scan_driver_if
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : seg7_decode                                               |
// | Purpose  : Combinational hex nibble to active-low segment pattern.   |
// | Ports    : i_nibble[4] hex digit, i_blank forces all segments off,   |
// |            o_seg[7] {g,f,e,d,c,b,a} active-low                       |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module seg7_decode
  import seg7_pkg::*;
(
  input  wire logic [3:0] i_nibble,
  input  wire logic       i_blank,
  output logic      [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_TABLE[i_nibble];
    if (i_blank) begin
      o_seg = SEG_BLANK;
    end
  end

endmodule : seg7_decode
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : seg7_scan_driver                                          |
// | Purpose  : Multiplexed DIGITS-wide seven-segment scan engine with    |
// |            hex decode, decimal points, leading-zero blanking, dead   |
// |            time between digits and frame-synchronous value updates.  |
// | Ports    : clk, rst (async, active-high)                             |
// |            bus (slave): en, value, dp_in, load, blank_lz in;         |
// |                         an, seg, dp, frame_done out (registered)     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int CLK_HZ      = 100_000_000,
  parameter int REFRESH_HZ  = 1000,
  parameter int DEAD_CYCLES = 16
) (
  input  wire logic          clk,
  input  wire logic          rst,
  seg7_scan_driver_if.slave  bus
);

  localparam int TICK   = tick_cycles(CLK_HZ, REFRESH_HZ);
  localparam int SLOT_W = width_for(TICK);
  localparam int DIG_W  = width_for(DIGITS);
  localparam int NIB_W  = 4 * DIGITS;

  localparam logic [SLOT_W-1:0] C_SLOT_LAST  = SLOT_W'(TICK - 1);
  localparam logic [SLOT_W-1:0] C_DEAD       = SLOT_W'(DEAD_CYCLES);
  localparam logic [DIG_W-1:0]  C_DIGIT_LAST = DIG_W'(DIGITS - 1);

  // Scan state
  logic [SLOT_W-1:0] r_slot;
  logic [DIG_W-1:0]  r_digit;

  // Pending (written by load) and display (sampled at frame start)
  logic [NIB_W-1:0]  r_pend_val;
  logic [DIGITS-1:0] r_pend_dp;
  logic [NIB_W-1:0]  r_disp_val;
  logic [DIGITS-1:0] r_disp_dp;

  // Registered outputs
  logic [DIGITS-1:0] r_an;
  logic [6:0]        r_seg;
  logic              r_dp;
  logic              r_frame_done;

  logic              w_frame_start;
  logic [NIB_W-1:0]  w_new_val;
  logic [DIGITS-1:0] w_new_dp;
  logic [NIB_W-1:0]  w_cur_val;
  logic [DIGITS-1:0] w_cur_dp;
  logic [DIGITS:0]   w_zero_from;
  logic [3:0]        w_nibble;
  logic              w_dp_bit;
  logic              w_lead_zero;
  logic [DIGITS-1:0] w_an_lit;
  logic [6:0]        w_seg_dec;
  logic [SLOT_W-1:0] w_slot_nxt;
  logic [DIG_W-1:0]  w_digit_nxt;
  logic [DIGITS-1:0] w_an_nxt;
  logic [6:0]        w_seg_nxt;
  logic              w_dp_nxt;
  logic              w_fd_nxt;

  // Counters sit at 0 while disabled, so the first enabled cycle is
  // automatically a frame start.
  assign w_frame_start = bus.en && (r_slot == '0) && (r_digit == '0);

  // A load coinciding with the frame start goes straight to the display.
  assign w_new_val = bus.load ? bus.value : r_pend_val;
  assign w_new_dp  = bus.load ? bus.dp_in : r_pend_dp;

  // Decode from the value the display register is about to hold so the
  // frame-start cycle already uses the new frame's contents.
  assign w_cur_val = w_frame_start ? w_new_val : r_disp_val;
  assign w_cur_dp  = w_frame_start ? w_new_dp  : r_disp_dp;

  // w_zero_from[k]: nibbles k..DIGITS-1 are all zero. Bit 0 is tied low
  // because the rightmost digit is always shown.
  assign w_zero_from[DIGITS] = 1'b1;
  assign w_zero_from[0]      = 1'b0;

  for (genvar k = 1; k < DIGITS; k++) begin : g_lz
    assign w_zero_from[k] = (w_cur_val[4*k +: 4] == 4'h0) && w_zero_from[k+1];
  end

  // Select the current digit's nibble, dp bit, blank flag and anode.
  always_comb begin
    w_nibble    = 4'h0;
    w_dp_bit    = 1'b0;
    w_lead_zero = 1'b0;
    w_an_lit    = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_digit == DIG_W'(i)) begin
        w_nibble    = w_cur_val[4*i +: 4];
        w_dp_bit    = w_cur_dp[i];
        w_lead_zero = w_zero_from[i];
        w_an_lit[i] = 1'b0;
      end
    end
  end

  seg7_decode u_decode (
    .i_nibble (w_nibble),
    .i_blank  (bus.blank_lz && w_lead_zero),
    .o_seg    (w_seg_dec)
  );

  // Next-state and next-output logic
  always_comb begin
    w_slot_nxt  = r_slot;
    w_digit_nxt = r_digit;
    w_an_nxt    = '1;
    w_seg_nxt   = SEG_BLANK;
    w_dp_nxt    = 1'b1;
    w_fd_nxt    = 1'b0;
    if (!bus.en) begin
      w_slot_nxt  = '0;
      w_digit_nxt = '0;
    end else begin
      if (r_slot == C_SLOT_LAST) begin
        w_slot_nxt  = '0;
        w_digit_nxt = (r_digit == C_DIGIT_LAST) ? '0 : r_digit + 1'b1;
      end else begin
        w_slot_nxt  = r_slot + 1'b1;
      end
      // Anodes stay off for the first DEAD_CYCLES of a slot so the
      // previous digit's segments never bleed into the next anode.
      if (r_slot >= C_DEAD) begin
        w_an_nxt  = w_an_lit;
        w_seg_nxt = w_seg_dec;
        w_dp_nxt  = ~w_dp_bit;
      end
      w_fd_nxt = (r_digit == C_DIGIT_LAST) && (r_slot == C_SLOT_LAST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot       <= '0;
      r_digit      <= '0;
      r_pend_val   <= '0;
      r_pend_dp    <= '0;
      r_disp_val   <= '0;
      r_disp_dp    <= '0;
      r_an         <= '1;
      r_seg        <= SEG_BLANK;
      r_dp         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_slot       <= w_slot_nxt;
      r_digit      <= w_digit_nxt;
      r_an         <= w_an_nxt;
      r_seg        <= w_seg_nxt;
      r_dp         <= w_dp_nxt;
      r_frame_done <= w_fd_nxt;
      if (bus.load) begin
        r_pend_val <= bus.value;
        r_pend_dp  <= bus.dp_in;
      end
      if (w_frame_start) begin
        r_disp_val <= w_new_val;
        r_disp_dp  <= w_new_dp;
      end
    end
  end

  assign bus.an         = r_an;
  assign bus.seg        = r_seg;
  assign bus.dp         = r_dp;
  assign bus.frame_done = r_frame_done;

endmodule : seg7_scan_driver
`default_nettype wire
